// File: rtl/snn_rate_classifier.sv
// rtl/snn_rate_classifier.sv - rate-coded spiking classifier with programmable weights
//
// Rate-encodes N_IN static enables into periodic spike trains, drives N_OUT
// leaky integrate-and-fire neurons through a runtime-written signed weight
// matrix, runs a WINDOW-cycle evaluation and reports the neuron with the most
// spikes through a valid/ack handshake.
//
// Optional feature: define SNN_REFRACTORY_EN to hold a neuron at zero and
// silent for REFRACTORY cycles after each spike.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_en           static channel enables, latched at start
//   start           begin an evaluation (IDLE only)
//   w_we/w_addr/w_data  weight write, index = out*N_IN + in (IDLE only)
//   spike_out       registered neuron spikes, zero outside RUN
//   busy            high in RUN and DONE
//   result_valid    high in HOLD, cleared by result_ack
//   result_idx/result_count/result_none  winning neuron, its count, no-spike flag
module snn_rate_classifier #(
  parameter int N_IN            = 4,
  parameter int N_OUT           = 2,
  parameter int SPIKE_PERIOD    = 6,
  parameter int THRESHOLD       = 18,
  parameter int LEAK            = 1,
  parameter int POTENTIAL_WIDTH = 8,
  parameter int WEIGHT_WIDTH    = 6,
  parameter int WINDOW          = 64,
  parameter int COUNT_WIDTH     = 8,
  parameter int REFRACTORY      = 2
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic [N_IN-1:0]                                          in_en,
  input  logic                                                     start,
  input  logic                                                     w_we,
  input  logic [((N_IN*N_OUT) > 1 ? $clog2(N_IN*N_OUT) : 1)-1:0]   w_addr,
  input  logic [WEIGHT_WIDTH-1:0]                                  w_data,
  output logic [N_OUT-1:0]                                         spike_out,
  output logic                                                     busy,
  output logic                                                     result_valid,
  input  logic                                                     result_ack,
  output logic [(N_OUT > 1 ? $clog2(N_OUT) : 1)-1:0]               result_idx,
  output logic [COUNT_WIDTH-1:0]                                   result_count,
  output logic                                                     result_none
);

  localparam int NW  = N_IN * N_OUT;
  localparam int AW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int IW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int PHW = (SPIKE_PERIOD > 1) ? $clog2(SPIKE_PERIOD) : 1;
  localparam int WCW = $clog2(WINDOW + 1);
  // Wide enough for v plus N_IN worst-case weights minus the leak, with sign.
  localparam int SW  = POTENTIAL_WIDTH + WEIGHT_WIDTH + $clog2(N_IN) + 1;

  localparam logic signed [SW-1:0]        VMAX_S = SW'((64'd1 << POTENTIAL_WIDTH) - 64'd1);
  localparam logic signed [SW-1:0]        LEAK_S = SW'(LEAK);
  localparam logic [POTENTIAL_WIDTH:0]    THR    = (POTENTIAL_WIDTH + 1)'(THRESHOLD);
  localparam logic [PHW-1:0]              PH_LAST  = PHW'(SPIKE_PERIOD - 1);
  localparam logic [WCW-1:0]              WIN_LAST = WCW'(WINDOW - 1);

  if (REFRACTORY < 0) begin : g_refractory_range
    $error("REFRACTORY must be non-negative");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_HOLD} state_t;

  state_t state, state_nxt;

  logic signed [WEIGHT_WIDTH-1:0]  weights [NW];
  logic [N_IN-1:0]                 en_lat;
  logic [PHW-1:0]                  phase;
  logic [WCW-1:0]                  win_cnt;
  logic [POTENTIAL_WIDTH-1:0]      v [N_OUT];
  logic [COUNT_WIDTH-1:0]          cnt [N_OUT];

`ifdef SNN_REFRACTORY_EN
  localparam int RFW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
  logic [RFW-1:0]                  refr [N_OUT];
`endif

  logic                            win_last;
  logic [N_IN-1:0]                 in_spike;
  logic signed [SW-1:0]            acc [N_OUT];
  logic [POTENTIAL_WIDTH-1:0]      v_clamp [N_OUT];
  logic [N_OUT-1:0]                fire;
  logic [IW-1:0]                   best_idx;
  logic [COUNT_WIDTH-1:0]          best_cnt;

  assign win_last = (win_cnt == WIN_LAST);
  assign in_spike = (state == S_RUN && phase == PH_LAST) ? en_lat : '0;

  // FSM next state and state-decoded outputs
  always_comb begin
    state_nxt    = state;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (win_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        result_valid = 1'b1;
        if (result_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Neuron integration: signed sum, clamp to the unsigned potential range, threshold.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      acc[j] = {{(SW - POTENTIAL_WIDTH){1'b0}}, v[j]};
      for (int i = 0; i < N_IN; i++) begin
        if (in_spike[i]) begin
          acc[j] = acc[j] + {{(SW - WEIGHT_WIDTH){weights[j*N_IN+i][WEIGHT_WIDTH-1]}},
                             weights[j*N_IN+i]};
        end
      end
      acc[j] = acc[j] - LEAK_S;
      if (acc[j][SW-1])          v_clamp[j] = '0;
      else if (acc[j] > VMAX_S)  v_clamp[j] = '1;
      else                       v_clamp[j] = acc[j][POTENTIAL_WIDTH-1:0];
      fire[j] = ({1'b0, v_clamp[j]} >= THR);
`ifdef SNN_REFRACTORY_EN
      if (refr[j] != '0) fire[j] = 1'b0;
`endif
    end
  end

  // Argmax with strict compare so ties resolve to the lowest index.
  always_comb begin
    best_idx = '0;
    best_cnt = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (cnt[j] > best_cnt) begin
        best_cnt = cnt[j];
        best_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) weights[k] <= '0;
      en_lat       <= '0;
      phase        <= '0;
      win_cnt      <= '0;
      spike_out    <= '0;
      result_idx   <= '0;
      result_count <= '0;
      result_none  <= 1'b0;
      for (int j = 0; j < N_OUT; j++) begin
        v[j]   <= '0;
        cnt[j] <= '0;
`ifdef SNN_REFRACTORY_EN
        refr[j] <= '0;
`endif
      end
    end else begin
      spike_out <= '0;
      // Index compare loop keeps out-of-range addresses from touching storage.
      if (state == S_IDLE && w_we) begin
        for (int k = 0; k < NW; k++) begin
          if (w_addr == AW'(k)) weights[k] <= w_data;
        end
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            en_lat       <= in_en;
            phase        <= '0;
            win_cnt      <= '0;
            result_idx   <= '0;
            result_count <= '0;
            result_none  <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
              v[j]   <= '0;
              cnt[j] <= '0;
`ifdef SNN_REFRACTORY_EN
              refr[j] <= '0;
`endif
            end
          end
        end
        S_RUN: begin
          phase   <= (phase == PH_LAST) ? '0 : phase + PHW'(1);
          win_cnt <= win_cnt + WCW'(1);
          // The last RUN update still counts, but its spike would land in DONE.
          spike_out <= win_last ? '0 : fire;
          for (int j = 0; j < N_OUT; j++) begin
`ifdef SNN_REFRACTORY_EN
            if (refr[j] != '0) begin
              refr[j] <= refr[j] - RFW'(1);
              v[j]    <= '0;
            end else
`endif
            if (fire[j]) begin
              v[j] <= '0;
              if (cnt[j] != '1) cnt[j] <= cnt[j] + COUNT_WIDTH'(1);
`ifdef SNN_REFRACTORY_EN
              refr[j] <= RFW'(REFRACTORY);
`endif
            end else begin
              v[j] <= v_clamp[j];
            end
          end
        end
        S_DONE: begin
          result_idx   <= best_idx;
          result_count <= best_cnt;
          result_none  <= (best_cnt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/snn_rate_classifier.md
# snn_rate_classifier

Parametrised N-input, M-output spiking classifier with programmable weights. It is the successor to the fixed two-input XOR top level. It rate-encodes N_IN static inputs into spike trains and drives N_OUT leaky integrate-and-fire neurons through a signed weight matrix written at runtime. It runs a fixed evaluation window and then reports the winning output neuron through a valid/ack handshake.

## Interface
- N_IN, 4, number of input channels (≥1)
- N_OUT, 2, number of output neurons (≥1)
- SPIKE_PERIOD, 6, encoder period in cycles (≥1)
- THRESHOLD, 18, firing threshold (unsigned)
- LEAK, 1, per-cycle membrane decrement
- POTENTIAL_WIDTH, 8, membrane potential width (unsigned)
- WEIGHT_WIDTH, 6, signed weight width
- WINDOW, 64, evaluation window length in cycles
- COUNT_WIDTH, 8, spike counter width
- REFRACTORY, 2, refractory cycles; used only with SNN_REFRACTORY_EN
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_en  in  N_IN  static channel enables (switches)
- start  in  1  begin evaluation; honoured only in IDLE
- w_we  in  1  weight write strobe; honoured only in IDLE
- w_addr  in  max(1,$clog2(N_IN*N_OUT))  weight index = out*N_IN + in
- w_data  in  WEIGHT_WIDTH  signed weight
- spike_out  out  N_OUT  registered neuron spikes
- busy  out  1  high in RUN and DONE
- result_valid  out  1  high in HOLD
- result_ack  in  1  consumes result
- result_idx  out  max(1,$clog2(N_OUT))  winning neuron
- result_count  out  COUNT_WIDTH  winner's spike count
- result_none  out  1  all counts zero

## Operation
- FSM states: IDLE, RUN, DONE, HOLD.
- IDLE → RUN on start. On that edge the block clears potentials, spike counters, encoder phase, window counter and refractory counters. It also latches in_en into en_lat.
- RUN lasts exactly WINDOW cycles, then goes to DONE.
- DONE lasts one cycle and registers the argmax. It then goes to HOLD.
- HOLD → IDLE on the edge where result_ack=1.
- Outside IDLE, start and w_we are ignored. A start coincident with w_we in IDLE performs both; the write lands before RUN.
- If w_addr ≥ N_IN*N_OUT, the write is ignored.
- Encoder phase counts 0..SPIKE_PERIOD-1 during RUN and wraps. Channel i spikes combinationally when phase==SPIKE_PERIOD-1 and en_lat[i]==1. With SPIKE_PERIOD=1 the channel spikes every cycle.
- Neuron update on each RUN cycle:
  - s = v + Σ w[j][i] over spiking i − LEAK, computed signed in POTENTIAL_WIDTH+WEIGHT_WIDTH+$clog2(N_IN)+1 bits.
  - The result clamps to [0, 2^POTENTIAL_WIDTH−1].
  - If clamped ≥ THRESHOLD, the neuron fires: spike_out[j]=1, v←0, and count_j increments, saturating at 2^COUNT_WIDTH−1.
  - Otherwise v←clamped and spike_out[j]=0.
- Argmax selects the highest count; ties go to the lowest index.
  - result_count is the maximum count.
  - result_none=1 when the maximum count is 0, with result_idx=0 in that case.
- Result registers and spike counts hold their values through HOLD and IDLE until the next start.

## Timing
- Reset values: every output is 0, state is IDLE, all weights are 0, and potentials, counters and en_lat are 0.
- Asserting rst mid-RUN or in HOLD aborts immediately. There is no partial result.
- Treat the start edge as E0:
  - RUN occupies cycles E0+1..E0+WINDOW.
  - busy is high from E0 to E0+WINDOW+1.
  - result_valid rises at E0+WINDOW+1.
- spike_out is one cycle after the input spike that causes it, and is forced to 0 outside RUN.
- The first encoder spike occurs in RUN cycle SPIKE_PERIOD, counting from 1.
- Changing in_en during RUN has no effect.
- result_ack in the first HOLD cycle is honoured. result_ack outside HOLD is ignored.

## Configuration
- SNN_REFRACTORY_EN defined:
  - After a neuron fires, that neuron ignores input for REFRACTORY cycles.
  - During those cycles v is held at 0 and no spike is produced.
  - The refractory counter is cleared by start and rst.
- Not defined: there is no refractory logic, and the REFRACTORY parameter is unused.

## Test plan
- Weight reset: rst pulse mid-RUN → outputs 0 and state IDLE within the same cycle. A subsequent start with no writes gives result_none=1, result_count=0.
- Single channel: w[0→0]=20, in_en=0001, defaults → spike_out[0] pulses at RUN cycles 7,13,…,61 (10 pulses), result_idx=0, result_count=10, result_valid at E0+65.
- Tie: w[0→0]=w[0→1]=20, in_en=0001 → both counts 10, result_idx=0.
- Inhibition: w[0→0]=20, w[1→0]=−20, in_en=0011 → no spikes, result_none=1, result_idx=0.
- Handshake: hold result_ack=0 for 100 cycles in HOLD and pulse start → result stable, start ignored. Then result_ack=1 → IDLE next cycle and busy=0.
- Refractory: SPIKE_PERIOD=1, REFRACTORY=2, w[0→0]=20, in_en=0001 → with macro result_count=22. Without macro result_count=64.
